// File: rtl/gpu_mem_pkg.sv
// Shared types and helpers for the GPU data-memory arbiter.
package gpu_mem_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    // Request type carried through the FSM; doubles as the RAM write enable
    localparam logic REQ_RD = 1'b0;
    localparam logic REQ_WR = 1'b1;

    // Ceiling log2, never below 1 so a single-channel build still has a legal index width
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IdxW = clog2(N)
) (
    input  logic [N-1:0]    i_req,
    input  logic [IdxW-1:0] i_ptr,
    output logic [N-1:0]    o_gnt,
    output logic [IdxW-1:0] o_gnt_idx,
    output logic            o_gnt_valid
);

    // Two passes: [ptr, N-1] first, then the wrapped range [0, ptr-1]
    always_comb begin
        o_gnt       = '0;
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_gnt_valid && i_req[j] && (j >= 32'(i_ptr))) begin
                o_gnt_valid = 1'b1;
                o_gnt[j]    = 1'b1;
                o_gnt_idx   = IdxW'(j);
            end
        end
        for (int unsigned j = 0; j < N; j++) begin
            if (!o_gnt_valid && i_req[j] && (j < 32'(i_ptr))) begin
                o_gnt_valid = 1'b1;
                o_gnt[j]    = 1'b1;
                o_gnt_idx   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/gpu_data_mem_arbiter.sv
// Shares one single-port synchronous RAM between the GPU data-memory channels.
// One access in flight at a time: IDLE (grant) -> ACCESS (RAM strobe) -> RESP (ready pulse).
module gpu_data_mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int unsigned DATA_MEM_ADDR_BITS    = 12,
    parameter int unsigned DATA_MEM_DATA_BITS    = 16,
    parameter int unsigned DATA_MEM_NUM_CHANNELS = 4
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic [DATA_MEM_NUM_CHANNELS-1:0]                    data_mem_read_valid,
    input  logic [DATA_MEM_NUM_CHANNELS*DATA_MEM_ADDR_BITS-1:0] data_mem_read_address,
    output logic [DATA_MEM_NUM_CHANNELS-1:0]                    data_mem_read_ready,
    output logic [DATA_MEM_NUM_CHANNELS*DATA_MEM_DATA_BITS-1:0] data_mem_read_data,
    input  logic [DATA_MEM_NUM_CHANNELS-1:0]                    data_mem_write_valid,
    input  logic [DATA_MEM_NUM_CHANNELS*DATA_MEM_ADDR_BITS-1:0] data_mem_write_address,
    input  logic [DATA_MEM_NUM_CHANNELS*DATA_MEM_DATA_BITS-1:0] data_mem_write_data,
    output logic [DATA_MEM_NUM_CHANNELS-1:0]                    data_mem_write_ready,
    output logic                                                ram_en,
    output logic                                                ram_we,
    output logic [DATA_MEM_ADDR_BITS-1:0]                       ram_addr,
    output logic [DATA_MEM_DATA_BITS-1:0]                       ram_wdata,
    input  logic [DATA_MEM_DATA_BITS-1:0]                       ram_rdata,
    output logic                                                busy
);

    localparam int unsigned N    = DATA_MEM_NUM_CHANNELS;
    localparam int unsigned A    = DATA_MEM_ADDR_BITS;
    localparam int unsigned D    = DATA_MEM_DATA_BITS;
    localparam int unsigned IdxW = clog2(N);

    state_e          r_state;
    state_e          w_state_next;
    logic [IdxW-1:0] r_ptr;
    logic [IdxW-1:0] r_ch;
    logic            r_type;
    logic [A-1:0]    r_addr;
    logic [D-1:0]    r_wdata;
    logic [N-1:0]    r_rd_served;
    logic [N-1:0]    r_wr_served;
    logic [N-1:0]    r_read_ready;
    logic [N-1:0]    r_write_ready;
    logic [N*D-1:0]  r_read_data;

    logic [N-1:0]    w_rd_elig;
    logic [N-1:0]    w_wr_elig;
    logic [N-1:0]    w_req;
    logic [N-1:0]    w_gnt;
    logic [IdxW-1:0] w_gnt_idx;
    logic            w_gnt_valid;
    logic            w_gnt_is_wr;
    logic            w_grant;
    logic            w_resp;
    logic [N-1:0]    w_ch_onehot;
    logic [N-1:0]    w_rd_set;
    logic [N-1:0]    w_wr_set;

    // A request already answered stays ineligible until its valid is seen low
    assign w_rd_elig = data_mem_read_valid & ~r_rd_served;
    assign w_wr_elig = data_mem_write_valid & ~r_wr_served;
    assign w_req     = w_rd_elig | w_wr_elig;

    rr_arbiter #(
        .N(N)
    ) u_rr_arbiter (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .o_gnt      (w_gnt),
        .o_gnt_idx  (w_gnt_idx),
        .o_gnt_valid(w_gnt_valid)
    );

    // Write wins over read on the same channel; the read stays pending
    assign w_gnt_is_wr = |(w_gnt & w_wr_elig);
    assign w_grant     = (r_state == StIdle) && w_gnt_valid;
    assign w_resp      = (r_state == StResp);
    assign w_ch_onehot = N'(1) << r_ch;
    assign w_rd_set    = (w_resp && (r_type == REQ_RD)) ? w_ch_onehot : '0;
    assign w_wr_set    = (w_resp && (r_type == REQ_WR)) ? w_ch_onehot : '0;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state and RAM-side outputs
    always_comb begin
        w_state_next = r_state;
        ram_en       = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_wdata    = '0;
        unique case (r_state)
            StIdle: begin
                if (w_gnt_valid) begin
                    w_state_next = StAccess;
                end
            end
            StAccess: begin
                ram_en       = 1'b1;
                ram_we       = r_type;
                ram_addr     = r_addr;
                ram_wdata    = r_wdata;
                w_state_next = StResp;
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    assign busy = (r_state != StIdle);

    // Capture the granted request so the channel may drop valid mid-flight
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch    <= '0;
            r_type  <= REQ_RD;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant) begin
            r_ch    <= w_gnt_idx;
            r_type  <= w_gnt_is_wr ? REQ_WR : REQ_RD;
            r_addr  <= w_gnt_is_wr ? data_mem_write_address[w_gnt_idx*A +: A]
                                   : data_mem_read_address[w_gnt_idx*A +: A];
            r_wdata <= data_mem_write_data[w_gnt_idx*D +: D];
        end
    end

    // Ready pulses, read data capture and pointer advance on completion
    always_ff @(posedge clk) begin
        if (reset) begin
            r_read_ready  <= '0;
            r_write_ready <= '0;
            r_read_data   <= '0;
            r_ptr         <= '0;
        end else begin
            r_read_ready  <= w_rd_set;
            r_write_ready <= w_wr_set;
            if (w_resp) begin
                if (r_type == REQ_RD) begin
                    r_read_data[r_ch*D +: D] <= ram_rdata;
                end
                if (32'(r_ch) == N - 1) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_ch + 1'b1;
                end
            end
        end
    end

    // Served flags: set with the ready pulse, cleared once valid is sampled low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_served <= '0;
            r_wr_served <= '0;
        end else begin
            r_rd_served <= (r_rd_served & data_mem_read_valid) | w_rd_set;
            r_wr_served <= (r_wr_served & data_mem_write_valid) | w_wr_set;
        end
    end

    assign data_mem_read_ready  = r_read_ready;
    assign data_mem_write_ready = r_write_ready;
    assign data_mem_read_data   = r_read_data;

endmodule
